// File: rtl/led_scan_pkg.sv
// Shared state and mode encodings for the LED scan engine.
package led_scan_pkg;

  typedef enum logic [1:0] {
    DWELL_LO = 2'd0,
    UP       = 2'd1,
    DWELL_HI = 2'd2,
    DOWN     = 2'd3
  } scan_state_t;

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROT_L  = 2'b01;
  localparam logic [1:0] MODE_ROT_R  = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

endpackage

// File: rtl/led_scan_engine_if.sv
// Control/status bundle between the register block and the LED scan engine.
// The trail signal exists only when LED_TRAIL_EN is defined.
interface led_scan_engine_if #(
  parameter int WIDTH   = 8,
  parameter int DIV_W   = 16,
  parameter int DWELL_W = 4
);
  localparam int POS_W = $clog2(WIDTH);

  logic               enable;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   step_div;
  logic [DWELL_W-1:0] dwell_lo;
  logic [DWELL_W-1:0] dwell_hi;
  logic [WIDTH-1:0]   count;
  logic [POS_W-1:0]   pos;
  logic               dir;
  logic               end_hit;
`ifdef LED_TRAIL_EN
  logic [WIDTH-1:0]   trail;
`endif

  modport master (
    output enable, mode, step_div, dwell_lo, dwell_hi,
`ifdef LED_TRAIL_EN
    input  trail,
`endif
    input  count, pos, dir, end_hit
  );

  modport slave (
    input  enable, mode, step_div, dwell_lo, dwell_hi,
`ifdef LED_TRAIL_EN
    output trail,
`endif
    output count, pos, dir, end_hit
  );

endinterface

// File: rtl/led_scan_prescaler.sv
// Step-rate prescaler: one tick every step_div+1 enabled cycles.
module led_scan_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] step_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // An equality compare lets a lowered step_div wrap through 2^DIV_W instead of locking up.
  assign tick = enable && (div_cnt == step_div);

  always_ff @(posedge clk) begin
    if (!reset)      div_cnt <= '0;
    else if (tick)   div_cnt <= '0;
    else if (enable) div_cnt <= div_cnt + 1'b1;
  end

endmodule

// File: rtl/led_scan_engine.sv
// One-hot LED scanner: bounce with end dwell, rotate either way, or hold.
// Optional LED_TRAIL_EN adds a two-lit comet trail output.
//
// state    | meaning
// DWELL_LO | parked at pos 0, counting down dwell_lo hold ticks
// UP       | bounce sweep toward WIDTH-1
// DWELL_HI | parked at pos WIDTH-1, counting down dwell_hi hold ticks
// DOWN     | bounce sweep toward 0
module led_scan_engine
  import led_scan_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIV_W   = 16,
  parameter int DWELL_W = 4
) (
  input logic            clk,
  input logic            reset,
  led_scan_engine_if.slave bus
);

  localparam int POS_W = $clog2(WIDTH);
  localparam logic [POS_W-1:0] LAST     = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] PRE_LAST = POS_W'(WIDTH - 2);
  localparam logic [POS_W-1:0] FIRST_UP = POS_W'(1);
  localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  scan_state_t        state, state_n, cur;
  logic [POS_W-1:0]   pos, pos_n;
  logic [WIDTH-1:0]   count;
  logic               dir, dir_n;
  logic [DWELL_W-1:0] dwell_cnt, dwell_n;
  logic               hit_q, hit_n;
  logic [1:0]         mode_q, mode_n;
  logic               tick;

  led_scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (bus.enable),
    .step_div (bus.step_div),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= DWELL_LO;
      pos       <= '0;
      count     <= ONE_HOT0;
      dir       <= 1'b0;
      dwell_cnt <= bus.dwell_lo;
      hit_q     <= 1'b0;
      mode_q    <= MODE_BOUNCE;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      count     <= ONE_HOT0 << pos_n;
      dir       <= dir_n;
      dwell_cnt <= dwell_n;
      hit_q     <= hit_n;
      mode_q    <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    dir_n   = dir;
    dwell_n = dwell_cnt;
    hit_n   = 1'b0;
    mode_n  = mode_q;
    cur     = state;
    if (tick) begin
      mode_n = bus.mode;
      case (bus.mode)
        MODE_BOUNCE: begin
          if (mode_q != MODE_BOUNCE && pos == LAST) begin
            state_n = DWELL_HI;
            dwell_n = bus.dwell_hi;
          end else if (mode_q != MODE_BOUNCE && pos == '0) begin
            state_n = DWELL_LO;
            dwell_n = bus.dwell_lo;
          end else begin
            if (mode_q != MODE_BOUNCE)
              cur = (mode_q == MODE_ROT_R) ? DOWN : UP;
            case (cur)
              DWELL_LO: begin
                if (dwell_cnt != '0) dwell_n = dwell_cnt - 1'b1;
                else begin
                  pos_n   = FIRST_UP;
                  dir_n   = 1'b0;
                  state_n = UP;
                end
              end
              UP: begin
                pos_n   = pos + 1'b1;
                dir_n   = 1'b0;
                state_n = UP;
              end
              DWELL_HI: begin
                if (dwell_cnt != '0) dwell_n = dwell_cnt - 1'b1;
                else begin
                  pos_n   = PRE_LAST;
                  dir_n   = 1'b1;
                  state_n = DOWN;
                end
              end
              DOWN: begin
                pos_n   = pos - 1'b1;
                dir_n   = 1'b1;
                state_n = DOWN;
              end
              default: ;
            endcase
            // A sweep step landing on an end parks there; this also covers WIDTH=2 dwell exits.
            if (state_n == UP && pos_n == LAST) begin
              state_n = DWELL_HI;
              dwell_n = bus.dwell_hi;
              hit_n   = 1'b1;
            end else if (state_n == DOWN && pos_n == '0) begin
              state_n = DWELL_LO;
              dwell_n = bus.dwell_lo;
              hit_n   = 1'b1;
            end
          end
        end
        MODE_ROT_L: begin
          pos_n = (pos == LAST) ? '0 : pos + 1'b1;
          dir_n = 1'b0;
          hit_n = (pos_n == LAST) || (pos_n == '0);
        end
        MODE_ROT_R: begin
          pos_n = (pos == '0) ? LAST : pos - 1'b1;
          dir_n = 1'b1;
          hit_n = (pos_n == LAST) || (pos_n == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.count   = count;
  assign bus.pos     = pos;
  assign bus.dir     = dir;
  assign bus.end_hit = hit_q & bus.enable;

`ifdef LED_TRAIL_EN
  logic [WIDTH-1:0] prev_count;

  // Refreshed on every tick, so a hold tick collapses the trail onto the lit bit.
  always_ff @(posedge clk) begin
    if (!reset)    prev_count <= ONE_HOT0;
    else if (tick) prev_count <= count;
  end

  assign bus.trail = count | prev_count;
`endif

endmodule

// File: tb/tb_led_scan_engine.sv
// Scoreboard bench for led_scan_engine: WIDTH=4 and WIDTH=8 instances share stimulus,
// each checked against an abstract bouncing-ball model; trail checked with LED_TRAIL_EN.
module tb_led_scan_engine;
  import led_scan_pkg::*;

  localparam int DIV_W   = 4;
  localparam int DWELL_W = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [1:0]         mode;
  logic [DIV_W-1:0]   step_div;
  logic [DWELL_W-1:0] dwell_lo, dwell_hi;

  always #5 clk = ~clk;

  led_scan_engine_if #(.WIDTH(4), .DIV_W(DIV_W), .DWELL_W(DWELL_W)) bus4 ();
  led_scan_engine_if #(.WIDTH(8), .DIV_W(DIV_W), .DWELL_W(DWELL_W)) bus8 ();

  assign bus4.enable = enable;   assign bus8.enable = enable;
  assign bus4.mode = mode;       assign bus8.mode = mode;
  assign bus4.step_div = step_div; assign bus8.step_div = step_div;
  assign bus4.dwell_lo = dwell_lo; assign bus8.dwell_lo = dwell_lo;
  assign bus4.dwell_hi = dwell_hi; assign bus8.dwell_hi = dwell_hi;

  led_scan_engine #(.WIDTH(4), .DIV_W(DIV_W), .DWELL_W(DWELL_W)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));
  led_scan_engine #(.WIDTH(8), .DIV_W(DIV_W), .DWELL_W(DWELL_W)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    logic [63:0] count;
    int          pos;
    bit          dir;
    bit          hit;
    logic [63:0] trail;
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  // Model: a ball that moves one step per tick and rests at each end for a dwell.
  int          widths[2] = '{4, 8};
  int          m_pos[2], m_rest[2], m_div[2];
  bit          m_down[2], m_resting[2], m_hit[2];
  logic [1:0]  m_prev_mode[2];
  logic [63:0] m_prev_cnt[2];

  function automatic void check(string name, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, got, want, $time);
    end
  endfunction

  task automatic ball_move(int k);
    m_pos[k] = m_pos[k] + (m_down[k] ? -1 : 1);
    if (m_pos[k] == 0 || m_pos[k] == widths[k] - 1) begin
      m_resting[k] = 1'b1;
      m_rest[k]    = (m_pos[k] == 0) ? int'(dwell_lo) : int'(dwell_hi);
      m_hit[k]     = 1'b1;
    end
  endtask

  task automatic model_step(int k, bit rst_n);
    exp_t e;
    bit   tick;
    int   w;
    w        = widths[k];
    m_hit[k] = 1'b0;
    if (!rst_n) begin
      m_pos[k] = 0; m_down[k] = 1'b0; m_resting[k] = 1'b1; m_rest[k] = int'(dwell_lo);
      m_div[k] = 0; m_prev_mode[k] = MODE_BOUNCE; m_prev_cnt[k] = 64'd1;
    end else begin
      tick = enable && (m_div[k] == int'(step_div));
      if (tick) m_div[k] = 0;
      else if (enable) m_div[k] = (m_div[k] + 1) % (1 << DIV_W);
      if (tick) begin
        m_prev_cnt[k] = 64'd1 << m_pos[k];
        case (mode)
          MODE_BOUNCE: begin
            if (m_prev_mode[k] != MODE_BOUNCE && (m_pos[k] == 0 || m_pos[k] == w - 1)) begin
              m_resting[k] = 1'b1;
              m_rest[k]    = (m_pos[k] == 0) ? int'(dwell_lo) : int'(dwell_hi);
            end else if (m_prev_mode[k] != MODE_BOUNCE) begin
              m_resting[k] = 1'b0;
              m_down[k]    = (m_prev_mode[k] == MODE_ROT_R);
              ball_move(k);
            end else if (m_resting[k] && m_rest[k] > 0) begin
              m_rest[k] = m_rest[k] - 1;
            end else begin
              if (m_resting[k]) begin
                m_resting[k] = 1'b0;
                m_down[k]    = (m_pos[k] != 0);
              end
              ball_move(k);
            end
          end
          MODE_ROT_L: begin
            m_pos[k] = (m_pos[k] + 1) % w; m_down[k] = 1'b0;
            m_hit[k] = (m_pos[k] == 0 || m_pos[k] == w - 1);
          end
          MODE_ROT_R: begin
            m_pos[k] = (m_pos[k] + w - 1) % w; m_down[k] = 1'b1;
            m_hit[k] = (m_pos[k] == 0 || m_pos[k] == w - 1);
          end
          default: ;
        endcase
        m_prev_mode[k] = mode;
      end
    end
    e.count = 64'd1 << m_pos[k];
    e.pos   = m_pos[k];
    e.dir   = m_down[k];
    e.hit   = m_hit[k];
    e.trail = e.count | m_prev_cnt[k];
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One clock: apply inputs, predict the outputs of the coming edge, wait past that edge.
  task automatic drive_cycle(input bit rst_n, input bit en, input logic [1:0] md,
                             input int sd, input int dl, input int dh);
    reset    = rst_n;
    enable   = en;
    mode     = md;
    step_div = DIV_W'(sd);
    dwell_lo = DWELL_W'(dl);
    dwell_hi = DWELL_W'(dh);
    model_step(0, rst_n);
    model_step(1, rst_n);
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (!done) begin
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("w4_count", 64'(bus4.count), e.count);
          check("w4_pos", 64'(bus4.pos), 64'(e.pos));
          check("w4_dir", 64'(bus4.dir), 64'(e.dir));
          check("w4_end_hit", 64'(bus4.end_hit), 64'(e.hit));
`ifdef LED_TRAIL_EN
          check("w4_trail", 64'(bus4.trail), e.trail);
`endif
        end
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("w8_count", 64'(bus8.count), e.count);
          check("w8_pos", 64'(bus8.pos), 64'(e.pos));
          check("w8_dir", 64'(bus8.dir), 64'(e.dir));
          check("w8_end_hit", 64'(bus8.end_hit), 64'(e.hit));
`ifdef LED_TRAIL_EN
          check("w8_trail", 64'(bus8.trail), e.trail);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin : driver
    int  tbl4[9] = '{1, 1, 2, 4, 8, 8, 4, 2, 1};
    int  tick_n, want;
    int  sd, dl, dh;
    bit  en, rn;
    logic [1:0] md;

    // Bounce, WIDTH=4, dwell 2/1: period of nine ticks.
    drive_cycle(1'b0, 1'b1, MODE_BOUNCE, 0, 2, 1);
    drive_cycle(1'b0, 1'b1, MODE_BOUNCE, 0, 2, 1);
    check("rst_count4", 64'(bus4.count), 64'd1);
    check("rst_pos8", 64'(bus8.pos), 64'd0);
    check("rst_dir8", 64'(bus8.dir), 64'd0);
    check("rst_end_hit8", 64'(bus8.end_hit), 64'd0);
    for (int i = 0; i < 18; i++) begin
      drive_cycle(1'b1, 1'b1, MODE_BOUNCE, 0, 2, 1);
      check("bounce4_seq", 64'(bus4.count), 64'(tbl4[i % 9]));
      check("bounce4_end_hit", 64'(bus4.end_hit), (i % 9 == 4 || i % 9 == 8) ? 64'd1 : 64'd0);
    end

    // step_div=3, dwell 0/0: one step per four cycles, full sweep in 56 cycles.
    drive_cycle(1'b0, 1'b1, MODE_BOUNCE, 3, 0, 0);
    for (int e = 1; e <= 56; e++) begin
      drive_cycle(1'b1, 1'b1, MODE_BOUNCE, 3, 0, 0);
      tick_n = e / 4;
      want   = (tick_n <= 7) ? tick_n : 14 - tick_n;
      check("sweep8_pos", 64'(bus8.pos), 64'(want));
    end

    // Rotate-left from reset.
    drive_cycle(1'b0, 1'b1, MODE_ROT_L, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b1, 1'b1, MODE_ROT_L, 0, 0, 0);
      check("rotl8_count", 64'(bus8.count), 64'd1 << (i % 8));
      check("rotl8_dir", 64'(bus8.dir), 64'd0);
      check("rotl8_end_hit", 64'(bus8.end_hit), (i % 8 == 7 || i % 8 == 0) ? 64'd1 : 64'd0);
    end

    // Freeze mid-sweep at 0x10 for ten cycles, then resume.
    drive_cycle(1'b0, 1'b1, MODE_BOUNCE, 1, 0, 0);
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, MODE_BOUNCE, 1, 0, 0);
    check("freeze8_start", 64'(bus8.count), 64'h10);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 1'b0, MODE_BOUNCE, 1, 0, 0);
      check("freeze8_count", 64'(bus8.count), 64'h10);
      check("freeze8_end_hit", 64'(bus8.end_hit), 64'd0);
    end
    drive_cycle(1'b1, 1'b1, MODE_BOUNCE, 1, 0, 0);
    check("resume8_wait", 64'(bus8.count), 64'h10);
    drive_cycle(1'b1, 1'b1, MODE_BOUNCE, 1, 0, 0);
    check("resume8_step", 64'(bus8.count), 64'h20);

    // Reset during the high-end dwell.
    drive_cycle(1'b0, 1'b1, MODE_BOUNCE, 0, 3, 5);
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b1, MODE_BOUNCE, 0, 3, 5);
    check("dwell_hi8_count", 64'(bus8.count), 64'h80);
    drive_cycle(1'b0, 1'b1, MODE_BOUNCE, 0, 3, 5);
    check("midreset8_count", 64'(bus8.count), 64'd1);
    check("midreset8_pos", 64'(bus8.pos), 64'd0);
    check("midreset8_dir", 64'(bus8.dir), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1'b1, 1'b1, MODE_BOUNCE, 0, 3, 5);
      check("dwell_lo8_restart", 64'(bus8.count), (i < 4) ? 64'd1 : 64'd2);
    end

    // Randomised mode, rate, dwell, enable and reset traffic.
    md = MODE_BOUNCE; sd = 0; dl = 1; dh = 2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) sd = int'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) begin
        dl = int'($urandom_range(0, 3));
        dh = int'($urandom_range(0, 3));
      end
      en = ($urandom_range(0, 7) != 0);
      rn = ($urandom_range(0, 399) != 0);
      drive_cycle(rn, en, md, sd, dl, dh);
    end

    done = 1'b1;
    check("drain_q4", 64'(q0.size()), 64'd0);
    check("drain_q8", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
